// File: rtl/alu_wide_seq.sv
// alu_wide_seq: runs a NUM_WORDS*WIDTH-bit add/sub/cmp/adc as a sequence of
// WIDTH-bit operations on one external ALU. It processes the LS word first,
// chains the carry through adc/sbc and accumulates Z over every word.
module alu_wide_seq #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NUM_WORDS = 4,
  parameter int unsigned FLAGS_W   = 4,
  parameter int unsigned OPER_W    = 3,
  parameter int unsigned FLAG_C    = 0,
  parameter int unsigned FLAG_Z    = 1,
  parameter logic [OPER_W-1:0] ALU_ADD = OPER_W'(0),
  parameter logic [OPER_W-1:0] ALU_SUB = OPER_W'(1),
  parameter logic [OPER_W-1:0] ALU_ADC = OPER_W'(2),
  parameter logic [OPER_W-1:0] ALU_SBC = OPER_W'(3)
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_start,
  input  logic [1:0]                   i_op_sel,
  input  logic [NUM_WORDS*WIDTH-1:0]   i_a_in,
  input  logic [NUM_WORDS*WIDTH-1:0]   i_b_in,
  input  logic [FLAGS_W-1:0]           i_flags_in,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [NUM_WORDS*WIDTH-1:0]   o_result,
  output logic [FLAGS_W-1:0]           o_flags_out,
  output logic [OPER_W-1:0]            o_alu_oper,
  output logic [WIDTH-1:0]             o_alu_a,
  output logic [WIDTH-1:0]             o_alu_b,
  output logic [FLAGS_W-1:0]           o_alu_flags_in,
  input  logic [WIDTH-1:0]             i_alu_out,
  input  logic [FLAGS_W-1:0]           i_alu_flags_out
);

  localparam int unsigned TOT_W = NUM_WORDS * WIDTH;
  localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_ADC = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_idx;
  logic [TOT_W-1:0]   r_a;
  logic [TOT_W-1:0]   r_b;
  logic [1:0]         r_op;
  logic [FLAGS_W-1:0] r_flags;
  logic               r_c;
  logic               r_z;
  logic [TOT_W-1:0]   r_result;
  logic [FLAGS_W-1:0] r_flags_out;
  logic               r_busy;
  logic               r_done;

  logic               w_last;
  logic               w_first;
  logic               w_subtract;
  logic [WIDTH-1:0]   w_word_a;
  logic [WIDTH-1:0]   w_word_b;
  logic [FLAGS_W-1:0] w_fin_flags;

  assign w_last     = (r_idx == IDX_W'(NUM_WORDS - 1));
  assign w_first    = (r_idx == '0);
  assign w_subtract = (r_op == OP_SUB) || (r_op == OP_CMP);

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_result    = r_result;
  assign o_flags_out = r_flags_out;

  // Next state, ALU drive for the current word, and final flag merge
  always_comb begin
    w_next         = r_state;
    o_alu_oper     = ALU_ADD;
    o_alu_a        = '0;
    o_alu_b        = '0;
    o_alu_flags_in = '0;
    w_word_a       = '0;
    w_word_b       = '0;
    w_fin_flags    = r_flags;

    for (int unsigned w = 0; w < NUM_WORDS; w++) begin
      if (r_idx == IDX_W'(w)) begin
        w_word_a = r_a[w*WIDTH +: WIDTH];
        w_word_b = r_b[w*WIDTH +: WIDTH];
      end
    end

    w_fin_flags[FLAG_C] = i_alu_flags_out[FLAG_C];
    w_fin_flags[FLAG_Z] = r_z & i_alu_flags_out[FLAG_Z];

    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_RUN;
      end
      S_RUN: begin
        o_alu_a                = w_word_a;
        o_alu_b                = w_word_b;
        o_alu_flags_in         = r_flags;
        o_alu_flags_in[FLAG_C] = r_c;
        if (r_op == OP_ADC)  o_alu_oper = ALU_ADC;
        else if (w_subtract) o_alu_oper = w_first ? ALU_SUB : ALU_SBC;
        else                 o_alu_oper = w_first ? ALU_ADD : ALU_ADC;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State, operand latch, carry/Z chaining and result capture
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= OP_ADD;
      r_flags     <= '0;
      r_c         <= 1'b0;
      r_z         <= 1'b1;
      r_result    <= '0;
      r_flags_out <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a     <= i_a_in;
            r_b     <= i_b_in;
            r_op    <= i_op_sel;
            r_flags <= i_flags_in;
            r_c     <= (i_op_sel == OP_ADC) ? i_flags_in[FLAG_C] : (i_op_sel != OP_ADD);
            r_z     <= 1'b1;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_c <= i_alu_flags_out[FLAG_C];
          r_z <= r_z & i_alu_flags_out[FLAG_Z];
          if (r_op != OP_CMP) begin
            for (int unsigned w = 0; w < NUM_WORDS; w++) begin
              if (r_idx == IDX_W'(w)) r_result[w*WIDTH +: WIDTH] <= i_alu_out;
            end
          end
          if (w_last) r_flags_out <= w_fin_flags;
          else        r_idx       <= r_idx + IDX_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_wide_seq.sv
// Testbench for alu_wide_seq: behavioural 8-bit ALU, directed vector table,
// random operations against a 32-bit arithmetic model, and corner sequences.
module tb_alu_wide_seq;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned T  = 32;
  localparam int unsigned FW = 4;
  localparam int unsigned OW = 3;
  localparam logic [OW-1:0] A_ADD = 3'd0;
  localparam logic [OW-1:0] A_SUB = 3'd1;
  localparam logic [OW-1:0] A_ADC = 3'd2;
  localparam logic [OW-1:0] A_SBC = 3'd3;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_ADC = 2'b11;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    op_sel;
  logic [T-1:0]  a_in, b_in;
  logic [FW-1:0] flags_in;
  logic          busy, done;
  logic [T-1:0]  result;
  logic [FW-1:0] flags_out;
  logic [OW-1:0] alu_oper;
  logic [W-1:0]  alu_a, alu_b, alu_out;
  logic [FW-1:0] alu_flags_in, alu_flags_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_wide_seq #(
    .WIDTH(W), .NUM_WORDS(N), .FLAGS_W(FW), .OPER_W(OW), .FLAG_C(0), .FLAG_Z(1),
    .ALU_ADD(A_ADD), .ALU_SUB(A_SUB), .ALU_ADC(A_ADC), .ALU_SBC(A_SBC)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_op_sel(op_sel),
    .i_a_in(a_in), .i_b_in(b_in), .i_flags_in(flags_in),
    .o_busy(busy), .o_done(done), .o_result(result), .o_flags_out(flags_out),
    .o_alu_oper(alu_oper), .o_alu_a(alu_a), .o_alu_b(alu_b),
    .o_alu_flags_in(alu_flags_in), .i_alu_out(alu_out),
    .i_alu_flags_out(alu_flags_out)
  );

  // Word ALU: flag bit0 = C (no-borrow for subtract), bit1 = Z, others pass through
  logic [W:0] s9;
  always_comb begin
    s9 = '0;
    case (alu_oper)
      A_ADD:   s9 = {1'b0, alu_a} + {1'b0, alu_b};
      A_ADC:   s9 = {1'b0, alu_a} + {1'b0, alu_b} + 9'(alu_flags_in[0]);
      A_SUB:   s9 = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
      A_SBC:   s9 = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'(alu_flags_in[0]);
      default: s9 = '0;
    endcase
    alu_out       = s9[W-1:0];
    alu_flags_out = {alu_flags_in[3:2], (s9[W-1:0] == '0), s9[W]};
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Wide reference: plain 32-bit arithmetic
  function automatic void ref_op(input logic [1:0] op, input logic [T-1:0] a, input logic [T-1:0] b,
                                 input logic [FW-1:0] fin, inout logic [T-1:0] res,
                                 output logic [FW-1:0] fl);
    logic [T:0]   s;
    logic [T-1:0] r;
    logic         c;
    if (op == OP_ADD || op == OP_ADC) begin
      s = {1'b0, a} + {1'b0, b} + ((op == OP_ADC) ? 33'(fin[0]) : 33'd0);
      r = s[T-1:0];
      c = s[T];
    end else begin
      r = a - b;
      c = (a >= b);
    end
    if (op != OP_CMP) res = r;
    fl    = fin;
    fl[0] = c;
    fl[1] = (r == '0);
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [T-1:0] a, input logic [T-1:0] b,
                        input logic [FW-1:0] fin, input bit mid_start,
                        output logic [T-1:0] res, output logic [FW-1:0] fl, output int dcyc);
    @(negedge clk);
    op_sel = op; a_in = a; b_in = b; flags_in = fin; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a_in = $urandom; b_in = $urandom; flags_in = 4'($urandom); op_sel = 2'($urandom);
    dcyc = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      start = (k == 2) && mid_start;
      if (k == 1) chk("busy_in_run", busy, 1);
      if (done) begin
        dcyc = k;
        break;
      end
    end
    start = 1'b0;
    res = result;
    fl  = flags_out;
    if (dcyc == 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: no done within 20 cycles");
    end
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [T-1:0]  a;
    logic [T-1:0]  b;
    logic [FW-1:0] fin;
    logic [T-1:0]  er;
    logic [FW-1:0] ef;
  } vec_t;

  vec_t          vt[8];
  logic [T-1:0]  got_r, model_r, ra, rb;
  logic [FW-1:0] got_f, exp_f, rf;
  logic [1:0]    rop;
  int            dc;

  initial begin
    vt[0] = '{OP_ADD, 32'h000000FF, 32'h00000001, 4'h0, 32'h00000100, 4'h0};
    vt[1] = '{OP_ADD, 32'hFFFFFFFF, 32'h00000001, 4'h0, 32'h00000000, 4'h3};
    vt[2] = '{OP_SUB, 32'h00010000, 32'h00000001, 4'h0, 32'h0000FFFF, 4'h1};
    vt[3] = '{OP_SUB, 32'h00000000, 32'h00000001, 4'h0, 32'hFFFFFFFF, 4'h0};
    vt[4] = '{OP_ADD, 32'hAA55AA55, 32'h00000000, 4'h0, 32'hAA55AA55, 4'h0};
    vt[5] = '{OP_CMP, 32'h12345678, 32'h12345678, 4'h0, 32'hAA55AA55, 4'h3};
    vt[6] = '{OP_ADC, 32'h00000000, 32'h00000000, 4'hD, 32'h00000001, 4'hC};
    vt[7] = '{OP_ADD, 32'h00000001, 32'h00000001, 4'hF, 32'h00000002, 4'hC};

    reset = 1'b1; start = 1'b0; op_sel = '0; a_in = '0; b_in = '0; flags_in = '0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", flags_out, 0);
    chk("rst_alu_oper", alu_oper, A_ADD);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_flags", alu_flags_in, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].fin, 1'b0, got_r, got_f, dc);
      chk($sformatf("vec%0d_result", i), got_r, vt[i].er);
      chk($sformatf("vec%0d_flags", i), got_f, vt[i].ef);
      chk($sformatf("vec%0d_done_cycle", i), dc, 5);
    end

    // Random operations, some with a stray start mid-run
    model_r = vt[7].er;
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom);
      if ($urandom_range(0, 3) == 0) rb = ~ra + 32'(rop == OP_ADD || rop == OP_ADC);
      rf  = 4'($urandom);
      ref_op(rop, ra, rb, rf, model_r, exp_f);
      run_op(rop, ra, rb, rf, 1'($urandom), got_r, got_f, dc);
      chk($sformatf("rnd%0d_op%0d_result", i, rop), got_r, model_r);
      chk($sformatf("rnd%0d_op%0d_flags", i, rop), got_f, exp_f);
      chk($sformatf("rnd%0d_done_cycle", i), dc, 5);
    end

    // Start held during the DONE cycle must be ignored
    run_op(OP_ADD, 32'd5, 32'd3, 4'h0, 1'b0, got_r, got_f, dc);
    chk("pre_done_start_result", got_r, 32'd8);
    @(negedge clk);
    op_sel = OP_ADD; a_in = 32'd1; b_in = 32'd1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("start_accepted_check", busy, 1);
    dc = 0;
    for (int k = 1; k <= 20; k++) begin
      if (done) begin
        dc = k;
        break;
      end
      @(negedge clk);
    end
    chk("second_op_done_cycle", dc, 5);
    start = 1'b1;
    a_in = 32'd100;
    @(negedge clk);
    chk("start_in_done_ignored", busy, 0);
    chk("start_in_done_result", result, 32'd2);
    start = 1'b0;
    @(negedge clk);
    chk("no_queued_start", busy, 0);

    // Reset in the middle of RUN clears everything without a clock edge
    @(negedge clk);
    op_sel = OP_ADD; a_in = 32'h01010101; b_in = 32'h01010101; flags_in = 4'hF; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    chk("midrst_flags", flags_out, 0);
    chk("midrst_alu_a", alu_a, 0);
    @(negedge clk);
    chk("midrst_no_done_after", done, 0);
    reset = 1'b0;
    run_op(OP_SUB, 32'h00000010, 32'h00000010, 4'h4, 1'b0, got_r, got_f, dc);
    chk("post_rst_result", got_r, 32'h0);
    chk("post_rst_flags", got_f, 4'h7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
